// File: rtl/hyperbus_responder.sv
// HyperBus target (HyperRAM-style) oversampled in the clk domain: decodes the 48-bit CA,
// applies initial latency and serves linear read/write bursts from an internal word memory.
`timescale 1ns/1ps

module hyperbus_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 7,
    parameter bit          FIXED_2X   = 1'b1,
    parameter logic [15:0] REG_ID0    = 16'h0C81,
    parameter logic [15:0] CR0_RESET  = 16'h8F1F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hbus_ck_i,
    input  logic       hbus_csn_i,
    input  logic [7:0] hbus_dq_i,
    output logic [7:0] hbus_dq_o,
    output logic       hbus_dq_oe,
    input  logic       hbus_rwds_i,
    output logic       hbus_rwds_o,
    output logic       hbus_rwds_oe,
    output logic       busy_o
);

    localparam logic [7:0] LAT_RISES = 8'(LATENCY * (FIXED_2X ? 2 : 1));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LATENCY,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t      state;
    logic        ck_meta, ck_s, ck_d;
    logic        csn_meta, csn_s;
    logic        rwds_meta, rwds_s;
    logic [7:0]  dq_meta, dq_s;
    logic        ck_rise, ck_fall, ck_edge;
    logic [2:0]  byte_cnt;
    logic [7:0]  lat_cnt;
    logic [31:0] addr;
    logic        is_read, is_reg;
    logic        hi_next;
    logic        reg_done;
    logic [15:0] cr0;
    logic [15:0] rd_word;
    logic        mem_we_hi, mem_we_lo;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [15:0] mem [0:(1 << ADDR_WIDTH) - 1];

    // Two sync flops per pin, all in parallel so a byte and its clock edge stay aligned;
    // ck_d is the history flop used only for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_meta   <= 1'b0;
            ck_s      <= 1'b0;
            ck_d      <= 1'b0;
            csn_meta  <= 1'b1;
            csn_s     <= 1'b1;
            rwds_meta <= 1'b0;
            rwds_s    <= 1'b0;
            dq_meta   <= '0;
            dq_s      <= '0;
        end else begin
            ck_meta   <= hbus_ck_i;
            ck_s      <= ck_meta;
            ck_d      <= ck_s;
            csn_meta  <= hbus_csn_i;
            csn_s     <= csn_meta;
            rwds_meta <= hbus_rwds_i;
            rwds_s    <= rwds_meta;
            dq_meta   <= hbus_dq_i;
            dq_s      <= dq_meta;
        end
    end

    assign ck_rise = ck_s & ~ck_d;
    assign ck_fall = ~ck_s & ck_d;
    assign ck_edge = ck_rise | ck_fall;
    assign mem_idx = addr[ADDR_WIDTH-1:0];
    assign busy_o  = (state != ST_IDLE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_word = mem[mem_idx];
        if (is_reg) begin
            rd_word = addr[11] ? cr0 : REG_ID0;
        end
    end

    assign mem_we_hi = (state == ST_WRITE) && !csn_s && ck_rise && hi_next && !is_reg && !rwds_s;
    assign mem_we_lo = (state == ST_WRITE) && !csn_s && ck_fall && !hi_next && !is_reg && !rwds_s;

    // NOTE: the memory array has no reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we_hi) mem[mem_idx][15:8] <= dq_s;
        if (mem_we_lo) mem[mem_idx][7:0]  <= dq_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            byte_cnt     <= '0;
            lat_cnt      <= '0;
            addr         <= '0;
            is_read      <= 1'b0;
            is_reg       <= 1'b0;
            hi_next      <= 1'b1;
            reg_done     <= 1'b0;
            cr0          <= CR0_RESET;
            hbus_dq_o    <= '0;
            hbus_dq_oe   <= 1'b0;
            hbus_rwds_o  <= 1'b0;
            hbus_rwds_oe <= 1'b0;
        end else if (csn_s) begin
            // Deselect beats any clock edge seen in the same cycle.
            state        <= ST_IDLE;
            hbus_dq_o    <= '0;
            hbus_dq_oe   <= 1'b0;
            hbus_rwds_o  <= 1'b0;
            hbus_rwds_oe <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state        <= ST_CA;
                    byte_cnt     <= '0;
                    hi_next      <= 1'b1;
                    reg_done     <= 1'b0;
                    hbus_rwds_oe <= 1'b1;
                    hbus_rwds_o  <= FIXED_2X;
                end
                ST_CA: if (ck_edge) begin
                    byte_cnt <= byte_cnt + 3'd1;
                    // CA bytes land straight in their fields; CA[45] and CA[15:3] are ignored.
                    case (byte_cnt)
                        3'd0: begin
                            is_read     <= dq_s[7];
                            is_reg      <= dq_s[6];
                            addr[31:27] <= dq_s[4:0];
                        end
                        3'd1: addr[26:19] <= dq_s;
                        3'd2: addr[18:11] <= dq_s;
                        3'd3: addr[10:3]  <= dq_s;
                        3'd5: begin
                            addr[2:0]    <= dq_s[2:0];
                            hbus_rwds_oe <= 1'b0;
                            hbus_rwds_o  <= 1'b0;
                            if (!is_read && is_reg) begin
                                state <= ST_WRITE;
                            end else begin
                                state   <= ST_LATENCY;
                                lat_cnt <= LAT_RISES;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_LATENCY: if (ck_rise) begin
                    if (lat_cnt <= 8'd1) begin
                        if (is_read) begin
                            state        <= ST_READ;
                            hbus_dq_oe   <= 1'b1;
                            hbus_rwds_oe <= 1'b1;
                            hbus_rwds_o  <= 1'b0;
                            hbus_dq_o    <= rd_word[15:8];
                        end else begin
                            state <= ST_WRITE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                ST_READ: begin
                    // Data starts on a rising edge: a fall before the first rise is skipped.
                    if (ck_rise && hi_next) begin
                        hbus_dq_o   <= rd_word[15:8];
                        hbus_rwds_o <= 1'b1;
                        hi_next     <= 1'b0;
                    end else if (ck_fall && !hi_next) begin
                        hbus_dq_o   <= rd_word[7:0];
                        hbus_rwds_o <= 1'b0;
                        hi_next     <= 1'b1;
                        addr        <= addr + 32'd1;
                    end
                end
                ST_WRITE: begin
                    if (ck_rise && hi_next) begin
                        hi_next <= 1'b0;
                        if (is_reg && !reg_done) cr0[15:8] <= dq_s;
                    end else if (ck_fall && !hi_next) begin
                        hi_next <= 1'b1;
                        addr    <= addr + 32'd1;
                        if (is_reg && !reg_done) begin
                            cr0[7:0] <= dq_s;
                            reg_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_responder.sv
// Bench acting as the HyperBus controller; a word-level model of memory and cr0 predicts
// every read byte, strobe level and output enable sampled just before each ck edge.
`timescale 1ns/1ps

module tb_hyperbus_responder;

    localparam int          AW        = 10;
    localparam int          DEPTH     = 1 << AW;
    localparam int          LAT_RISES = 14;
    localparam logic [15:0] REG_ID0   = 16'h0C81;
    localparam logic [15:0] CR0_RESET = 16'h8F1F;

    logic       clk = 1'b0;
    logic       rst;
    logic       ck;
    logic       csn;
    logic [7:0] dq_i;
    logic       rwds_i;
    logic [7:0] dq_o;
    logic       dq_oe;
    logic       rwds_o;
    logic       rwds_oe;
    logic       busy_o;

    hyperbus_responder dut (
        .clk          (clk),
        .rst          (rst),
        .hbus_ck_i    (ck),
        .hbus_csn_i   (csn),
        .hbus_dq_i    (dq_i),
        .hbus_dq_o    (dq_o),
        .hbus_dq_oe   (dq_oe),
        .hbus_rwds_i  (rwds_i),
        .hbus_rwds_o  (rwds_o),
        .hbus_rwds_oe (rwds_oe),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_mem [DEPTH];
    logic [15:0] model_cr0;
    logic [15:0] rd_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One half ck period = 4 clk; inputs change just after a negedge, outputs are read 4 negedges later.
    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [47:0] make_ca(input bit rd, input bit rg, input logic [31:0] wa);
        logic [47:0] c;
        c        = '0;
        c[47]    = rd;
        c[46]    = rg;
        c[45]    = 1'($urandom_range(0, 1));
        c[44:16] = wa[31:3];
        c[15:3]  = 13'($urandom);
        c[2:0]   = wa[2:0];
        return c;
    endfunction

    function automatic logic [15:0] model_word(input bit rg, input logic [31:0] wa);
        if (rg) return wa[11] ? model_cr0 : REG_ID0;
        return model_mem[wa[AW-1:0]];
    endfunction

    task automatic begin_xfer(input bit rd, input bit rg, input logic [31:0] wa);
        logic [47:0] ca;
        logic [15:0] first;
        int          lat;
        csn = 1'b0;
        ck  = 1'b0;
        half();
        check("busy_in_ca", 32'(busy_o), 32'd1);
        check("rwds_oe_in_ca", 32'(rwds_oe), 32'd1);
        check("rwds_latency_flag", 32'(rwds_o), 32'd1);
        ca = make_ca(rd, rg, wa);
        for (int i = 0; i < 6; i++) begin
            dq_i = ca[47 - 8 * i -: 8];
            ck   = ~ck;
            half();
        end
        check("rwds_oe_after_ca", 32'(rwds_oe), 32'd0);
        lat = (!rd && rg) ? 0 : LAT_RISES;
        for (int i = 0; i < lat; i++) begin
            ck = 1'b1;
            half();
            ck = 1'b0;
            half();
        end
        if (rd) begin
            first = model_word(rg, wa);
            check("rd_oe_after_latency", 32'({dq_oe, rwds_oe, rwds_o}), 32'b110);
            check("rd_preload_byte", 32'(dq_o), 32'(first[15:8]));
        end else begin
            check("wr_dq_oe_low", 32'(dq_oe), 32'd0);
        end
    endtask

    task automatic end_xfer();
        csn    = 1'b1;
        ck     = 1'b0;
        dq_i   = '0;
        rwds_i = 1'b0;
        half();
        check("idle_after_cs", 32'({busy_o, dq_oe, rwds_oe}), 32'd0);
    endtask

    task automatic write_words(input bit rg, input logic [31:0] wa,
                               input logic [15:0] data [$], input logic [1:0] mask [$]);
        logic [31:0] a;
        begin_xfer(1'b0, rg, wa);
        for (int i = 0; i < data.size(); i++) begin
            dq_i   = data[i][15:8];
            rwds_i = mask[i][1];
            ck     = 1'b1;
            half();
            dq_i   = data[i][7:0];
            rwds_i = mask[i][0];
            ck     = 1'b0;
            half();
            a = wa + 32'(i);
            if (rg) begin
                if (i == 0) model_cr0 = data[i];
            end else begin
                if (!mask[i][1]) model_mem[a[AW-1:0]][15:8] = data[i][15:8];
                if (!mask[i][0]) model_mem[a[AW-1:0]][7:0]  = data[i][7:0];
            end
        end
        end_xfer();
    endtask

    task automatic read_words(input bit rg, input logic [31:0] wa, input int n);
        logic [15:0] exp;
        logic [7:0]  got_hi;
        rd_q.delete();
        begin_xfer(1'b1, rg, wa);
        for (int i = 0; i < n; i++) begin
            exp = model_word(rg, wa + 32'(i));
            ck  = 1'b1;
            half();
            got_hi = dq_o;
            check("rd_hi", 32'(dq_o), 32'(exp[15:8]));
            check("rd_strobe_hi", 32'({dq_oe, rwds_o}), 32'b11);
            ck = 1'b0;
            half();
            check("rd_lo", 32'(dq_o), 32'(exp[7:0]));
            check("rd_strobe_lo", 32'(rwds_o), 32'd0);
            rd_q.push_back({got_hi, dq_o});
        end
        end_xfer();
    endtask

    task automatic write1(input bit rg, input logic [31:0] wa, input logic [15:0] w, input logic [1:0] m);
        logic [15:0] d [$];
        logic [1:0]  k [$];
        d.push_back(w);
        k.push_back(m);
        write_words(rg, wa, d, k);
    endtask

    initial begin
        logic [15:0] d [$];
        logic [1:0]  k [$];
        logic [31:0] wa;
        int          n;

        rst       = 1'b1;
        csn       = 1'b1;
        ck        = 1'b0;
        dq_i      = '0;
        rwds_i    = 1'b0;
        model_cr0 = CR0_RESET;
        #23;
        check("reset_outputs", 32'({dq_o, dq_oe, rwds_o, rwds_oe, busy_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Register read at 0: ID0 with strobe toggling.
        read_words(1'b1, 32'h0, 1);
        check("t1_id0_literal", 32'(rd_q[0]), 32'h0C81);

        // Fill all of memory so every later read has a defined expectation.
        d.delete(); k.delete();
        for (int i = 0; i < DEPTH; i++) begin
            d.push_back(16'($urandom));
            k.push_back(2'b00);
        end
        write_words(1'b0, 32'h0, d, k);

        d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        k = '{2'b00, 2'b00, 2'b00, 2'b00};
        write_words(1'b0, 32'h010, d, k);
        read_words(1'b0, 32'h010, 4);
        check("t2_lit_w0", 32'(rd_q[0]), 32'h1111);
        check("t2_lit_w3", 32'(rd_q[3]), 32'h4444);

        write1(1'b0, 32'h020, 16'hFFFF, 2'b00);
        write1(1'b0, 32'h020, 16'hAABB, 2'b10);
        read_words(1'b0, 32'h020, 1);
        check("t3_masked_literal", 32'(rd_q[0]), 32'hFFBB);

        d = '{16'hCAFE, 16'hBEEF};
        k = '{2'b00, 2'b00};
        write_words(1'b0, 32'(DEPTH - 1), d, k);
        read_words(1'b0, 32'(DEPTH - 1), 2);
        check("t4_wrap_w1", 32'(rd_q[1]), 32'hBEEF);
        read_words(1'b0, 32'h0, 1);
        check("t4_wrap_at_0", 32'(rd_q[0]), 32'hBEEF);

        write1(1'b1, 32'h0, 16'h8F17, 2'b11);
        read_words(1'b1, 32'h800, 1);
        check("t5_cr0_literal", 32'(rd_q[0]), 32'h8F17);

        // CS# raised after only the high byte of a write.
        write1(1'b0, 32'h030, 16'h1234, 2'b00);
        begin_xfer(1'b0, 1'b0, 32'h030);
        dq_i   = 8'h5A;
        rwds_i = 1'b0;
        ck     = 1'b1;
        half();
        csn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_busy_drop_3clk", 32'(busy_o), 32'd0);
        model_mem[AW'(32'h030)][15:8] = 8'h5A;
        ck = 1'b0;
        @(negedge clk);
        half();
        read_words(1'b0, 32'h030, 1);
        check("t5_partial_literal", 32'(rd_q[0]), 32'h5A34);

        // Randomized mix of bursts checked against the model.
        for (int t = 0; t < 60; t++) begin
            wa = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    n = $urandom_range(1, 4);
                    d.delete(); k.delete();
                    for (int i = 0; i < n; i++) begin
                        d.push_back(16'($urandom));
                        k.push_back({($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
                    end
                    write_words(1'b0, wa, d, k);
                end
                1: read_words(1'b0, wa, $urandom_range(1, 4));
                2: read_words(1'b1, wa, $urandom_range(1, 3));
                default: begin
                    n = $urandom_range(1, 2);
                    d.delete(); k.delete();
                    for (int i = 0; i < n; i++) begin
                        d.push_back(16'($urandom));
                        k.push_back(2'($urandom));
                    end
                    write_words(1'b1, wa, d, k);
                end
            endcase
        end

        // Asynchronous reset in the middle of a read burst.
        begin_xfer(1'b1, 1'b0, 32'h010);
        ck = 1'b1;
        half();
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_reset", 32'({dq_oe, rwds_oe, busy_o}), 32'd0);
        model_cr0 = CR0_RESET;
        csn = 1'b1;
        ck  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_words(1'b1, 32'h0, 1);
        check("t6_id0_after_reset", 32'(rd_q[0]), 32'h0C81);
        read_words(1'b1, 32'h800, 1);
        check("t6_cr0_reset_literal", 32'(rd_q[0]), 32'h8F1F);
        read_words(1'b0, 32'h010, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
